apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

APB completer (slave) that terminates one of the core's APB requester ports (general or program memory bus) on a word-addressed, 16-bit on-chip RAM. Responds to setup/access phases with a programmable number of wait states, commits writes on the completing access cycle and returns registered read data. Sits outside the core, one instance per APB bus, directly on the PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY wires.

## Interface
- ADDR_BITS, 9, RAM index width; depth = 2^ADDR_BITS words
- DATA_BITS, 16, word width (PWDATA/PRDATA)
- WAIT_STATES, 1, PREADY-low access cycles per transfer (0..15)

- CLOCK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- PADDR  in  16  word address
- PPROT  in  3  protection attributes (used only with macro)
- PSEL  in  1  slave select
- PENABLE  in  1  access phase marker
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_BITS  write data
- PRDATA  out  DATA_BITS  read data, registered
- PREADY  out  1  transfer complete, registered
- PSLVERR  out  1  error response, registered (tied 0 without macro)

## Operation
- FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE: PSEL=1 & PENABLE=0 -> SETUP; capture PADDR, PWRITE, PWDATA, PPROT; load wait counter with WAIT_STATES. PSEL=1 & PENABLE=1 in IDLE is a protocol violation: ignored, stay IDLE, PREADY stays 0.
- SETUP (first access cycle pending): counter==0 -> DONE, else -> WAIT.
- WAIT: counter decrements each cycle; reaching 0 -> DONE.
- DONE: PREADY=1 for exactly one cycle; write committed at the end of this cycle if captured PWRITE=1 and address in range; PRDATA loaded with mem[addr] (reads) at the edge entering DONE. Next state: IDLE, or SETUP directly if PSEL=1 & PENABLE=0 sampled in the DONE cycle is not allowed (APB requires PENABLE=1 there) -> always IDLE, new setup accepted from the following cycle.
- PSEL sampled 0 in SETUP or WAIT: abort -> IDLE, no write, PREADY stays 0.
- Address in range when PADDR[15:ADDR_BITS]==0. Out of range: read returns 0, write dropped.
- PRDATA holds its value outside DONE; write transfers leave PRDATA unchanged.
- RAM contents not affected by RESET.

## Timing
- Reset values: PREADY=0, PRDATA=0, PSLVERR=0, FSM=IDLE, counter=0.
- Setup cycle T; access starts T+1; PREADY=1 in cycle T+1+WAIT_STATES; transfer length 2+WAIT_STATES cycles.
- Minimum spacing between transfers: one IDLE cycle after DONE (back-to-back throughput 3+WAIT_STATES cycles).
- RESET asserted any cycle: next cycle all outputs at reset values; in-flight write not committed.
- Counter width 4 bits; WAIT_STATES>15 is illegal (elaboration error).

## Configuration
- APB_SLV_ERR_EN defined: PSLVERR=1 in the DONE cycle when address out of range, or write with PPROT[2]=1 (instruction access); such writes dropped. PSLVERR 0 in all other cycles.
- Undefined: PSLVERR tied 0; PPROT ignored; out-of-range behaviour unchanged (read 0, write dropped).

## Test plan
- Reset: hold RESET 2 cycles mid-idle -> PREADY=0, PRDATA=0x0000, PSLVERR=0.
- WAIT_STATES=2: write 0xBEEF to 0x0005, read 0x0005 -> PREADY low 2 access cycles, high in 3rd; PRDATA=0xBEEF.
- WAIT_STATES=0: writes 0x1FF<-0xA5A5, 0x000<-0x5A5A, read both -> each transfer 2 cycles, PRDATA 0xA5A5 then 0x5A5A.
- Out-of-range: write 0x0200<-0x1234, read 0x0000 and 0x0200 -> mem[0] unchanged, 0x0200 reads 0x0000; PSLVERR=1 on both 0x0200 transfers with APB_SLV_ERR_EN, 0 without.
- Abort: WAIT_STATES=3, write 0x0010<-0xFFFF, drop PSEL in 2nd wait cycle -> no PREADY, later read 0x0010 returns old value.
- RESET during WAIT of write 0x0020<-0x7777 -> outputs reset next cycle, read 0x0020 returns old value.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between one requester port and apb_mem_slave.
// Signal names follow the APB wire names used on the core's requester ports.
interface apb_mem_slave_if #(
  parameter int DATA_BITS = 16
);

  logic [15:0]          PADDR;
  logic [2:0]           PPROT;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DATA_BITS-1:0] PWDATA;
  logic [DATA_BITS-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  // Requester side: drives address/control/write data, receives the response.
  modport master (
    output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // Completer side: the memory slave.
  modport slave (
    input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_slave.sv
// APB completer in front of a word-addressed on-chip RAM.
//
// A transfer is a setup cycle followed by WAIT_STATES access cycles with
// PREADY low and one completing cycle (DONE) with PREADY high. Read data is
// fetched from the RAM at the edge entering DONE; writes commit at the end
// of DONE. Addresses with any bit set above ADDR_BITS read as 0 and are
// never written.
//
// Optional feature macro: APB_SLV_ERR_EN
//   defined   - PSLVERR flags out-of-range transfers and writes with
//               PPROT[2]=1 (instruction access); those writes are dropped.
//   undefined - PSLVERR is tied 0 and PPROT is ignored.
module apb_mem_slave #(
  parameter int ADDR_BITS   = 9,
  parameter int DATA_BITS   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  apb_mem_slave_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Reject configurations the 4-bit wait counter or the 16-bit address
  // cannot represent.
  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("apb_mem_slave: WAIT_STATES must be in 0..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 15) begin : g_bad_addr_bits
      $error("apb_mem_slave: ADDR_BITS must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // RAM array; contents are deliberately left out of reset.
  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic [15:0]          addr_reg;
  logic                 write_reg;
  logic [DATA_BITS-1:0] wdata_reg;
  logic                 ready_reg;
  logic [DATA_BITS-1:0] rdata_reg;

  logic                 setup_req;
  logic [3:0]           cnt_dec;
  logic                 done_next;
  logic [15:0]          sel_addr;
  logic                 sel_write;
  logic                 sel_in_range;
  logic                 reg_in_range;
  logic                 wr_allowed;

  assign setup_req = bus.PSEL && !bus.PENABLE;
  assign cnt_dec   = cnt_reg - 4'd1;

  // With zero wait states DONE is entered straight from IDLE, before the
  // transfer attributes are captured, so take them from the bus in that case.
  assign sel_addr  = (state_reg == ST_IDLE) ? bus.PADDR  : addr_reg;
  assign sel_write = (state_reg == ST_IDLE) ? bus.PWRITE : write_reg;

  assign sel_in_range = (sel_addr[15:ADDR_BITS] == '0);
  assign reg_in_range = (addr_reg[15:ADDR_BITS] == '0);

  // Decide whether the coming edge moves the FSM into DONE.
  always_comb begin
    done_next = 1'b0;
    case (state_reg)
      ST_IDLE:           done_next = setup_req && (WAIT_STATES == 0);
      ST_SETUP, ST_WAIT: done_next = bus.PSEL && (cnt_dec == 4'd0);
      default:           done_next = 1'b0;
    endcase
  end

`ifdef APB_SLV_ERR_EN
  logic [2:0] pprot_reg;
  logic [2:0] sel_prot;
  logic       err_next;
  logic       slverr_reg;

  assign sel_prot   = (state_reg == ST_IDLE) ? bus.PPROT : pprot_reg;
  assign err_next   = !sel_in_range || (sel_write && sel_prot[2]);
  assign wr_allowed = reg_in_range && !pprot_reg[2];

  // Error response flag, high only during DONE of a faulting transfer.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pprot_reg  <= 3'd0;
      slverr_reg <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && setup_req) begin
        pprot_reg <= bus.PPROT;
      end
      slverr_reg <= done_next && err_next;
    end
  end

  assign bus.PSLVERR = slverr_reg;
`else
  logic unused_pprot;

  assign unused_pprot = ^bus.PPROT;
  assign wr_allowed   = reg_in_range;
  assign bus.PSLVERR  = 1'b0;
`endif

  // Transfer FSM with registered PREADY/PRDATA.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 16'd0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      ready_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= 1'b0;

      if (done_next) begin
        state_reg <= ST_DONE;
        cnt_reg   <= 4'd0;
        ready_reg <= 1'b1;
        if (!sel_write) begin
          rdata_reg <= sel_in_range ? mem[sel_addr[ADDR_BITS-1:0]] : '0;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          // PSEL with PENABLE already high here is a protocol violation
          // and is ignored.
          if (setup_req) begin
            addr_reg  <= bus.PADDR;
            write_reg <= bus.PWRITE;
            wdata_reg <= bus.PWDATA;
            if (!done_next) begin
              state_reg <= ST_SETUP;
              cnt_reg   <= WAIT_INIT;
            end
          end
        end

        ST_SETUP, ST_WAIT: begin
          if (!bus.PSEL) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
          end else if (!done_next) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= cnt_dec;
          end
        end

        ST_DONE: begin
          // A new setup is only accepted from the cycle after DONE.
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // RAM write port: commit the captured write at the end of the DONE cycle.
  always_ff @(posedge CLOCK) begin
    if (!RESET && state_reg == ST_DONE && write_reg && wr_allowed) begin
      mem[addr_reg[ADDR_BITS-1:0]] <= wdata_reg;
    end
  end

  assign bus.PREADY = ready_reg;
  assign bus.PRDATA = rdata_reg;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances with WAIT_STATES 2, 0 and 3
// share clock and reset; each transfer pushes its expected response to a
// scoreboard queue that is popped when PREADY is seen.
module tb_apb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] paddr_d   [3];
  logic [2:0]  pprot_d   [3];
  logic        psel_d    [3];
  logic        penable_d [3];
  logic        pwrite_d  [3];
  logic [15:0] pwdata_d  [3];
  logic [15:0] prdata_o  [3];
  logic        pready_o  [3];
  logic        pslverr_o [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_unit
      apb_mem_slave_if #(.DATA_BITS(16)) bus ();

      assign bus.PADDR   = paddr_d[gi];
      assign bus.PPROT   = pprot_d[gi];
      assign bus.PSEL    = psel_d[gi];
      assign bus.PENABLE = penable_d[gi];
      assign bus.PWRITE  = pwrite_d[gi];
      assign bus.PWDATA  = pwdata_d[gi];
      assign prdata_o[gi]  = bus.PRDATA;
      assign pready_o[gi]  = bus.PREADY;
      assign pslverr_o[gi] = bus.PSLVERR;

      apb_mem_slave #(
        .ADDR_BITS   (9),
        .DATA_BITS   (16),
        .WAIT_STATES ((gi == 0) ? 2 : ((gi == 1) ? 0 : 3))
      ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
      );
    end
  endgenerate

  typedef struct {
    logic [15:0] rdata;
    logic        slverr;
    int          ws;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] model_mem [3][512];
  logic [15:0] last_rd   [3];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic int ws_of(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 0 : 3);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full APB transfer on unit u; returns after sampling the DONE cycle with
  // the bus still selected, so the next setup may follow immediately.
  task automatic xfer(input int u, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [2:0] prot, input string tag);
    exp_t e;
    exp_t got_e;
    bit   oor;
    bit   err;
    bit   done;
    int   n;
    oor = (addr[15:9] != 7'd0);
`ifdef APB_SLV_ERR_EN
    err = oor || (wr && prot[2]);
`else
    err = 1'b0;
`endif
    e.ws     = ws_of(u);
    e.slverr = err;
    if (wr) begin
      e.rdata = last_rd[u];
      if (!oor && !err) model_mem[u][addr[8:0]] = wdata;
    end else begin
      e.rdata    = oor ? 16'h0000 : model_mem[u][addr[8:0]];
      last_rd[u] = e.rdata;
    end
    sb_q.push_back(e);

    @(posedge clk); #1;
    psel_d[u]    = 1'b1;
    penable_d[u] = 1'b0;
    pwrite_d[u]  = wr;
    paddr_d[u]   = addr;
    pwdata_d[u]  = wdata;
    pprot_d[u]   = prot;
    @(negedge clk);
    check_val({tag, "_setup_ready"}, 32'(pready_o[u]), 32'd0);
    @(posedge clk); #1;
    penable_d[u] = 1'b1;

    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pready_o[u]) done = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    got_e = sb_q.pop_front();
    check_val({tag, "_done"},   32'(done),         32'd1);
    check_val({tag, "_wait"},   32'(n),            32'(got_e.ws));
    check_val({tag, "_rdata"},  32'(prdata_o[u]),  32'(got_e.rdata));
    check_val({tag, "_slverr"}, 32'(pslverr_o[u]), 32'(got_e.slverr));
    $display("xfer u%0d %s %s addr=0x%04h wdata=0x%04h prdata=0x%04h waits=%0d slverr=%0b",
             u, tag, wr ? "WR" : "RD", addr, wdata, prdata_o[u], n, pslverr_o[u]);
  endtask

  task automatic bus_idle(input int u, input int cycles);
    @(posedge clk); #1;
    psel_d[u]    = 1'b0;
    penable_d[u] = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 3; u++) begin
      check_val($sformatf("%s_u%0d_ready", tag, u),  32'(pready_o[u]),  32'd0);
      check_val($sformatf("%s_u%0d_rdata", tag, u),  32'(prdata_o[u]),  32'd0);
      check_val($sformatf("%s_u%0d_slverr", tag, u), 32'(pslverr_o[u]), 32'd0);
      last_rd[u] = 16'h0000;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      paddr_d[u] = 16'h0; pprot_d[u] = 3'd0; psel_d[u] = 1'b0;
      penable_d[u] = 1'b0; pwrite_d[u] = 1'b0; pwdata_d[u] = 16'h0;
      last_rd[u] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    // WAIT_STATES=2
    xfer(0, 1'b1, 16'h0005, 16'hBEEF, 3'd0, "ws2_wr");
    xfer(0, 1'b0, 16'h0005, 16'h0000, 3'd0, "ws2_rd");
    bus_idle(0, 2);

    // WAIT_STATES=0, back-to-back, range boundaries
    xfer(1, 1'b1, 16'h01FF, 16'hA5A5, 3'd0, "ws0_wr_top");
    xfer(1, 1'b1, 16'h0000, 16'h5A5A, 3'd0, "ws0_wr_bot");
    xfer(1, 1'b0, 16'h01FF, 16'h0000, 3'd0, "ws0_rd_top");
    xfer(1, 1'b0, 16'h0000, 16'h0000, 3'd0, "ws0_rd_bot");
    // out of range
    xfer(1, 1'b1, 16'h0200, 16'h1234, 3'd0, "oor_wr");
    xfer(1, 1'b0, 16'h0000, 16'h0000, 3'd0, "oor_rd0");
    xfer(1, 1'b0, 16'h0200, 16'h0000, 3'd0, "oor_rd");
    // instruction-access write
    xfer(1, 1'b1, 16'h0001, 16'h0BAD, 3'd0, "prot_pre");
    xfer(1, 1'b1, 16'h0001, 16'h4321, 3'b100, "prot_wr");
    xfer(1, 1'b0, 16'h0001, 16'h0000, 3'd0, "prot_rd");
    bus_idle(1, 1);

    // PSEL and PENABLE together in IDLE: ignored
    @(posedge clk); #1;
    psel_d[1] = 1'b1; penable_d[1] = 1'b1; pwrite_d[1] = 1'b0; paddr_d[1] = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val($sformatf("viol_ready_%0d", c), 32'(pready_o[1]), 32'd0);
    end
    bus_idle(1, 1);

    // Abort on WAIT_STATES=3: PSEL dropped in the second wait cycle
    xfer(2, 1'b1, 16'h0010, 16'h1111, 3'd0, "ws3_wr");
    xfer(2, 1'b0, 16'h0010, 16'h0000, 3'd0, "ws3_rd");
    bus_idle(2, 1);
    @(posedge clk); #1;
    psel_d[2] = 1'b1; penable_d[2] = 1'b0; pwrite_d[2] = 1'b1;
    paddr_d[2] = 16'h0010; pwdata_d[2] = 16'hFFFF;
    @(posedge clk); #1 penable_d[2] = 1'b1;
    @(negedge clk);
    check_val("abort_ready_a0", 32'(pready_o[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("abort_ready_a1", 32'(pready_o[2]), 32'd0);
    @(posedge clk); #1;
    psel_d[2] = 1'b0; penable_d[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val($sformatf("abort_ready_b%0d", c), 32'(pready_o[2]), 32'd0);
    end
    $display("abort u2 write 0x0010 dropped");
    xfer(2, 1'b0, 16'h0010, 16'h0000, 3'd0, "abort_rd");
    bus_idle(2, 1);

    // Reset while a write on WAIT_STATES=2 is in its wait cycle
    xfer(0, 1'b1, 16'h0020, 16'h3333, 3'd0, "rstw_pre");
    xfer(0, 1'b0, 16'h0020, 16'h0000, 3'd0, "rstw_prerd");
    bus_idle(0, 1);
    @(posedge clk); #1;
    psel_d[0] = 1'b1; penable_d[0] = 1'b0; pwrite_d[0] = 1'b1;
    paddr_d[0] = 16'h0020; pwdata_d[0] = 16'h7777;
    @(posedge clk); #1 penable_d[0] = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel_d[0] = 1'b0; penable_d[0] = 1'b0;
    @(negedge clk);
    check_reset_outputs("rstw");
    $display("reset during wait u0 write 0x0020");
    xfer(0, 1'b0, 16'h0020, 16'h0000, 3'd0, "rstw_rd");
    bus_idle(0, 1);

    // Reset held two cycles while idle
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("idle_rst");
    #1 rst = 1'b0;
    $display("idle reset done");
    xfer(1, 1'b0, 16'h01FF, 16'h0000, 3'd0, "post_rst_rd");
    bus_idle(1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
